ifetch_ctrl: RTL
================

# ifetch_ctrl

Fetch-side consumer of the program counter. It takes the current fetch address and issues one request at a time to instruction memory over a valid/ready handshake. Returned instructions are queued with their PC in a small buffer for decode. It drives `StallF` back to the PC register, so the PC advances only when a fetch request has been accepted.

## Interface
Parameters:
- `DEPTH`, 4: instruction buffer entries; power of two, ≥2.
- `XLEN`, 32: address and instruction width.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `PC`  in  XLEN  current fetch address from the PC register.
- `FlushF`  in  1  redirect: discard buffered and in-flight fetches.
- `StallF`  out  1  high holds the PC register.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  XLEN  fetch address; equals `PC`.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_rsp_valid`  in  1  response data valid; always accepted.
- `imem_rsp_data`  in  XLEN  fetched instruction word.
- `instr_valid`  out  1  buffer head valid.
- `instr_data`  out  XLEN  head instruction.
- `instr_pc`  out  XLEN  PC of the head instruction.
- `instr_ready`  in  1  decode consumes the head.

## Operation
- FSM states:
  - `REQ`: may issue.
  - `WAIT`: one request outstanding.
  - `DROP`: outstanding response must be discarded.
- `imem_req_valid` = state==`REQ` & !`FlushF` & (count + 0) < `DEPTH`. The single outstanding slot is reserved at issue, so a response never finds the buffer full.
- Handshake `imem_req_valid & imem_req_ready`:
  - latch `PC` into `pend_pc`;
  - go to `WAIT`.
- `StallF` = !`FlushF` & !(`imem_req_valid & imem_req_ready`).
- In `WAIT`, `imem_rsp_valid`:
  - push {`pend_pc`, `imem_rsp_data`};
  - go to `REQ`.
- In `WAIT` with `FlushF`:
  - go to `DROP`, or to `REQ` if the response arrives in the same cycle; that response is not pushed.
- In `DROP`, `imem_rsp_valid`:
  - discard the response;
  - go to `REQ`.
- `imem_rsp_valid` in `REQ` is ignored.
- `FlushF` in any state:
  - buffer count, read pointer and write pointer cleared at the next edge;
  - no request issued that cycle;
  - `StallF` low, so the PC loads the redirect target.
- Pop when `instr_valid & instr_ready`.
- Push and pop in the same cycle are legal at any occupancy; count is unchanged.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Count is `$clog2(DEPTH)+1` bits.

## Timing
- Reset values:
  - state `REQ`;
  - count 0;
  - `instr_valid` 0;
  - `instr_data`, `instr_pc` 0;
  - `imem_req_valid` follows its equation: high after reset, since the buffer is empty.
- Request accepted at edge N. Response arrives at N+1 at the earliest. The entry is visible on `instr_*` at N+2, because buffer outputs are registered.
- Maximum throughput is one instruction per two cycles for single-cycle memory.
- `imem_req_addr`, `imem_req_valid` and `StallF` are combinational from `PC`, state and count. `instr_*` come from registers.
- A reset asserted mid-transaction returns to `REQ` immediately. Any later stray response is ignored, because the state is `REQ`.

## Configuration
- `IFETCH_BYPASS_EN` defined:
  - when the buffer is empty and the response is accepted, `instr_valid`/`instr_data`/`instr_pc` are driven combinationally from the response in the same cycle;
  - if `instr_ready` is also high, the entry is consumed and not written;
  - latency becomes N+1.
- Undefined: all outputs are registered, with latency N+2 as above.

## Structure
- `ifetch_pkg` holds:
  - the `ifetch_state_e` enum (`REQ`, `WAIT`, `DROP`);
  - the `fetch_entry_t` struct {pc, instr};
  - `RESET_VECTOR` = 32'h8000_0000, shared with the PC register.
- Sub-module `ifetch_fifo`: a synchronous FIFO of `fetch_entry_t` with push, pop, flush and count.
- FSM and handshake logic live in `ifetch_ctrl`.

## Test plan
- Reset release with `PC`=0x8000_0000 and `imem_req_ready`=1:
  - `imem_req_valid`=1 and `StallF`=0 in the first cycle;
  - `StallF`=1 in the next cycle (`WAIT`).
- Response 0x00000013 one cycle after acceptance, then `instr_ready`=1:
  - `instr_valid`=1, `instr_data`=0x00000013 and `instr_pc`=0x8000_0000 two cycles after acceptance;
  - count returns to 0 after the pop.
- `instr_ready`=0 with `DEPTH`=4:
  - exactly 4 requests are issued;
  - then `imem_req_valid`=0 and `StallF`=1 are held;
  - one pop re-enables one request.
- `FlushF` pulse in `WAIT`, with the response arriving 2 cycles later:
  - the response is dropped and the buffer is empty;
  - the next request carries the redirect `PC` (e.g. 0x8000_0100).
- `imem_req_ready`=0 for 5 cycles:
  - `StallF`=1 throughout;
  - `imem_req_addr` is stable;
  - exactly one acceptance occurs when ready rises.
- `reset` asserted while in `WAIT`:
  - all outputs return to their reset values asynchronously;
  - the late response is ignored and the buffer stays empty.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch front end.
//   ifetch_state_e : fetch controller FSM state (REQ, WAIT, DROP)
//   fetch_entry_t  : one buffered fetch result {pc, instr}
//   RESET_VECTOR   : first fetch address after reset, shared with the PC register
package ifetch_pkg;

    localparam int          FETCH_W      = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,   // free to issue a request
        WAIT = 2'd1,   // one request outstanding
        DROP = 2'd2    // outstanding response belongs to a flushed path
    } ifetch_state_e;

    typedef struct packed {
        logic [FETCH_W-1:0] pc;
        logic [FETCH_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO of fetch_entry_t with registered head outputs.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           clears count and pointers at the next edge (push/pop ignored)
//   push/push_entry write one entry
//   pop             consume the head
//   count           current occupancy (0..DEPTH)
//   head_valid      registered: buffer not empty
//   head_entry      registered copy of the head entry (zero when empty)
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         head_valid,
    output fetch_entry_t                 head_entry
);

    localparam int                PTR_W  = $clog2(DEPTH);
    localparam int                CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(DEPTH);

    fetch_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               head_valid_r;
    fetch_entry_t       head_entry_r;

    logic               push_en_s;
    logic               pop_en_s;
    logic [PTR_W-1:0]   rd_ptr_next_s;
    logic [PTR_W-1:0]   wr_ptr_next_s;
    logic [CNT_W-1:0]   count_next_s;
    logic               head_valid_next_s;
    fetch_entry_t       head_next_s;

    // Qualify push/pop and precompute the post-edge pointers, count and head.
    always_comb begin
        pop_en_s  = pop & !flush & (count_r != '0);
        push_en_s = push & !flush & ((count_r != FULL_C) | pop_en_s);
        if (flush) begin
            rd_ptr_next_s = '0;
            wr_ptr_next_s = '0;
            count_next_s  = '0;
        end else begin
            rd_ptr_next_s = rd_ptr_r + PTR_W'(pop_en_s);
            wr_ptr_next_s = wr_ptr_r + PTR_W'(push_en_s);
            count_next_s  = count_r + CNT_W'(push_en_s) - CNT_W'(pop_en_s);
        end
        head_valid_next_s = (count_next_s != '0);
        // The entry being written this edge becomes the head when it lands
        // exactly at the next read position (buffer otherwise empty).
        if (!head_valid_next_s) begin
            head_next_s = '0;
        end else if (push_en_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = push_entry;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Pointer, count and registered head state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
            head_valid_r <= 1'b0;
            head_entry_r <= '0;
        end else begin
            rd_ptr_r     <= rd_ptr_next_s;
            wr_ptr_r     <= wr_ptr_next_s;
            count_r      <= count_next_s;
            head_valid_r <= head_valid_next_s;
            head_entry_r <= head_next_s;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    assign count      = count_r;
    assign head_valid = head_valid_r;
    assign head_entry = head_entry_r;

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetch controller. Issues one instruction-memory request at a
// time for the current PC, buffers returned instructions with their PC and
// holds the PC register (StallF) until a request is accepted.
// Ports:
//   CLK, reset                     clock, asynchronous active-low reset
//   PC, FlushF, StallF             PC register interface / redirect
//   imem_req_valid/addr/ready      request handshake (addr = PC)
//   imem_rsp_valid/data            response, always accepted
//   instr_valid/data/pc/ready      buffer head towards decode
// Build option: define IFETCH_BYPASS_EN to forward a response straight to
// decode when the buffer is empty (latency one cycle shorter).
// XLEN must match ifetch_pkg::FETCH_W.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [XLEN-1:0] PC,
    input  logic            FlushF,
    output logic            StallF,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    ifetch_state_e      state_r;
    logic [XLEN-1:0]    pend_pc_r;
    logic [CNT_W-1:0]   count_s;
    logic               req_fire_s;
    logic               push_s;
    logic               fifo_push_s;
    logic               fifo_pop_s;
    logic               head_valid_s;
    fetch_entry_t       rsp_entry_s;
    fetch_entry_t       head_entry_s;

    // Request/stall decode. Issuing only while count < DEPTH reserves a slot
    // for the single outstanding response, so a push never finds it full.
    always_comb begin
        imem_req_valid = (state_r == REQ) & !FlushF & (count_s < DEPTH_C);
        imem_req_addr  = PC;
        req_fire_s     = imem_req_valid & imem_req_ready;
        StallF         = !FlushF & !req_fire_s;
        push_s         = (state_r == WAIT) & imem_rsp_valid & !FlushF;
        rsp_entry_s.pc    = pend_pc_r;
        rsp_entry_s.instr = imem_rsp_data;
    end

`ifdef IFETCH_BYPASS_EN
    // Empty buffer: present the response to decode in the same cycle; it is
    // only written into the FIFO if decode does not take it right away.
    always_comb begin
        if (push_s && (count_s == '0)) begin
            instr_valid = 1'b1;
            instr_data  = imem_rsp_data;
            instr_pc    = pend_pc_r;
            fifo_push_s = !instr_ready;
        end else begin
            instr_valid = head_valid_s;
            instr_data  = head_entry_s.instr;
            instr_pc    = head_entry_s.pc;
            fifo_push_s = push_s;
        end
        fifo_pop_s = head_valid_s & instr_ready;
    end
`else
    // Decode sees only the registered FIFO head.
    always_comb begin
        instr_valid = head_valid_s;
        instr_data  = head_entry_s.instr;
        instr_pc    = head_entry_s.pc;
        fifo_push_s = push_s;
        fifo_pop_s  = head_valid_s & instr_ready;
    end
`endif

    // Fetch FSM; a response that coincides with a flush in WAIT is dropped
    // (push_s is gated) and the FSM goes straight back to REQ.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r   <= REQ;
            pend_pc_r <= '0;
        end else begin
            case (state_r)
                REQ: begin
                    if (req_fire_s) begin
                        state_r   <= WAIT;
                        pend_pc_r <= PC;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state_r <= REQ;
                    end else if (FlushF) begin
                        state_r <= DROP;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state_r <= REQ;
                    end
                end
                default: state_r <= REQ;
            endcase
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (reset),
        .flush      (FlushF),
        .push       (fifo_push_s),
        .push_entry (rsp_entry_s),
        .pop        (fifo_pop_s),
        .count      (count_s),
        .head_valid (head_valid_s),
        .head_entry (head_entry_s)
    );

endmodule
